btn_debounce_pulse: RTL
=======================

Name: btn_debounce_pulse

Overview:
- Front-end conditioning stage that sits directly upstream of the ALU operand/opcode register bank on the board.
- Synchronises the raw switch and push-button inputs and debounces each button.
- Converts each debounced press into a single-cycle, one-hot load strobe, so that each physical press loads exactly one register exactly once.
- Outputs connect 1:1 to the switch and button inputs of the register bank.

Parameters:
- N_SW, 6, width of the switch bus
- N_B, 3, number of push-buttons; output strobe width
- DEB_CYCLES, 1000000, consecutive stable samples required to accept a level change (10 ms at 100 MHz); legal range >= 2
- CNT_W, 20, debounce counter width; must satisfy 2^CNT_W > DEB_CYCLES

Ports:
- clock, input, 1, system clock; all logic on the rising edge
- reset, input, 1, synchronous, active-high; clears all state
- i_SWs_raw, input, N_SW, asynchronous slide switches
- i_buttons_raw, input, N_B, asynchronous push-buttons, active-high
- o_SWs, output, N_SW, synchronised switches
- o_buttons, output, N_B, one-hot single-cycle load strobe; bit N_B-1 = load A, bit 1 = load B, bit 0 = load OP
- o_held, output, N_B, debounced level of each button, for status LEDs

Behaviour:
- Reset values:
  - o_SWs = 0, o_buttons = 0, o_held = 0.
  - All synchroniser flops = 0, all counters = 0, all FSMs in IDLE.
  - Reset asserted mid-debounce or mid-hold aborts that operation immediately; no strobe is emitted for it.
  - After reset deasserts, a button that is still held is treated as a new press and is debounced from zero.
- Synchronisers:
  - Two flip-flop stages on every switch bit and every button bit.
  - o_SWs is the second-stage output, so it lags the raw switch by 2 edges.
  - A strobe is never issued in the same cycle as an unsynchronised switch value.
- Per-button FSM, one instance per bit; s = synchronised button level:
  - IDLE: cnt = 0. If s = 1, go to PRESS_WAIT with cnt = 1.
  - PRESS_WAIT:
    - If s = 0, go to IDLE and set cnt = 0.
    - Else if cnt = DEB_CYCLES-1, go to HELD and raise the press event.
    - Else cnt++.
  - HELD: o_held bit = 1. If s = 0, go to RELEASE_WAIT with cnt = 1.
  - RELEASE_WAIT:
    - If s = 1, return to HELD and set cnt = 0.
    - Else if cnt = DEB_CYCLES-1, go to IDLE with o_held bit = 0.
    - Else cnt++.
  - Result: any glitch shorter than DEB_CYCLES samples is ignored in both directions.
  - No strobe is generated on release or while the button stays in HELD, so auto-repeat is excluded.
- Strobe timing:
  - A press event registers into o_buttons, which is high for exactly 1 cycle.
  - Total latency: the strobe is high in the cycle after edge e0+DEB_CYCLES+1, where e0 is the first edge that samples the raw button high.
  - Example: with DEB_CYCLES = 4, the strobe appears after edge e0+5.
- Simultaneous press events in the same cycle:
  - Only the highest-index bit is strobed.
  - Lower-index events are dropped, not queued; their FSMs still enter HELD.
  - o_buttons is therefore always 0 or one-hot.
- Counters saturate by construction and never wrap. CNT_W below the required width is a configuration error.

Test Plan:
- Reset hold: reset = 1 for 3 cycles with all raw inputs = 1 -> o_SWs = 0, o_buttons = 0, o_held = 0 throughout. After release, with DEB_CYCLES = 4 -> one strobe o_buttons = 3'b100 after 5 edges.
- Clean press (DEB_CYCLES = 4): i_buttons_raw = 3'b010 held for 20 cycles, then 0 -> o_buttons = 3'b010 for exactly 1 cycle, 5 edges after first sample. o_held[1] high until 4 samples after the synchronised release.
- Bounce: raw bit 0 toggles 1,0,1,1,0,1 cycle-by-cycle, then stays 1 -> no strobe during bounce; exactly one 3'b001 strobe 4 stable samples after the last toggle.
- Release bounce: while in HELD, raw drops for 2 cycles and returns -> o_held stays 1, no second strobe.
- Simultaneous press: raw 3'b111 applied in one cycle -> single strobe 3'b100; o_held = 3'b111; no later strobes for bits 1 and 0.
- Switch path and reset abort:
  - i_SWs_raw = 6'h2A -> o_SWs = 6'h2A after 2 edges.
  - Reset pulsed at cnt = 2 of PRESS_WAIT -> no strobe.
  - Button still held after reset -> fresh strobe DEB_CYCLES+1 edges after reset release.

Source files
------------

// File: rtl/btn_debounce_pulse.sv
// Input conditioning for the ALU register bank: two-flop synchronisers on the switches and
// buttons, per-button debounce FSMs, and a one-hot single-cycle load strobe per accepted press.

module btn_debounce_pulse_chk #(
  parameter int N_B = 3
) (
  input logic           clock,
  input logic           reset,
  input logic [N_B-1:0] o_buttons,
  input logic [N_B-1:0] o_held
);

  a_strobe_onehot0: assert property (@(posedge clock) disable iff (reset) $onehot0(o_buttons));
  a_strobe_held:    assert property (@(posedge clock) disable iff (reset) ((o_buttons & ~o_held) == '0));

endmodule

module btn_debounce_pulse #(
  parameter int N_SW       = 6,
  parameter int N_B        = 3,
  parameter int DEB_CYCLES = 1000000,
  parameter int CNT_W      = 20
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_SW-1:0] i_SWs_raw,
  input  logic [N_B-1:0]  i_buttons_raw,
  output logic [N_SW-1:0] o_SWs,
  output logic [N_B-1:0]  o_buttons,
  output logic [N_B-1:0]  o_held
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

  // The count runs 1..DEB_CYCLES-1 and is then cleared, so it can never wrap.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [N_SW-1:0] sw_meta_r;
  logic [N_B-1:0]  btn_meta_r;
  logic [N_B-1:0]  btn_sync_r;
  logic [N_B-1:0]  press_evt_s;
  logic [N_B-1:0]  held_s;
  logic [N_B-1:0]  strobe_s;
  logic            found_s;

  // Two-flop synchronisers; the second switch stage drives o_SWs directly.
  always_ff @(posedge clock) begin
    if (reset) begin
      sw_meta_r  <= '0;
      o_SWs      <= '0;
      btn_meta_r <= '0;
      btn_sync_r <= '0;
    end else begin
      sw_meta_r  <= i_SWs_raw;
      o_SWs      <= sw_meta_r;
      btn_meta_r <= i_buttons_raw;
      btn_sync_r <= btn_meta_r;
    end
  end

  for (genvar g = 0; g < N_B; g++) begin : g_btn
    deb_state_t       state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             held_r;

    // Debounce FSM: a level change is accepted after DEB_CYCLES consecutive equal samples.
    always_ff @(posedge clock) begin
      if (reset) begin
        state_r <= IDLE;
        cnt_r   <= '0;
        held_r  <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            held_r <= 1'b0;
            if (btn_sync_r[g]) begin
              state_r <= PRESS_WAIT;
              cnt_r   <= CNT_W'(1);
            end else begin
              cnt_r   <= '0;
            end
          end
          PRESS_WAIT: begin
            if (!btn_sync_r[g]) begin
              state_r <= IDLE;
              cnt_r   <= '0;
            end else if (cnt_r == CNT_LAST) begin
              state_r <= HELD;
              cnt_r   <= '0;
              held_r  <= 1'b1;
            end else begin
              cnt_r   <= cnt_r + CNT_W'(1);
            end
          end
          HELD: begin
            held_r <= 1'b1;
            if (!btn_sync_r[g]) begin
              state_r <= RELEASE_WAIT;
              cnt_r   <= CNT_W'(1);
            end else begin
              cnt_r   <= '0;
            end
          end
          RELEASE_WAIT: begin
            if (btn_sync_r[g]) begin
              state_r <= HELD;
              cnt_r   <= '0;
            end else if (cnt_r == CNT_LAST) begin
              state_r <= IDLE;
              cnt_r   <= '0;
              held_r  <= 1'b0;
            end else begin
              cnt_r   <= cnt_r + CNT_W'(1);
            end
          end
          default: begin
            state_r <= IDLE;
            cnt_r   <= '0;
            held_r  <= 1'b0;
          end
        endcase
      end
    end

    // The press event coincides with the PRESS_WAIT -> HELD transition edge.
    assign press_evt_s[g] = (state_r == PRESS_WAIT) && btn_sync_r[g] && (cnt_r == CNT_LAST);
    assign held_s[g]      = held_r;
  end

  assign o_held = held_s;

  // Keep only the highest-index press event; lower ones are dropped, not queued.
  always_comb begin
    strobe_s = '0;
    found_s  = 1'b0;
    for (int i = N_B - 1; i >= 0; i--) begin
      if (press_evt_s[i] && !found_s) begin
        strobe_s[i] = 1'b1;
        found_s     = 1'b1;
      end else begin
        strobe_s[i] = 1'b0;
      end
    end
  end

  // Registered load strobe, high for exactly one cycle per accepted press.
  always_ff @(posedge clock) begin
    if (reset) begin
      o_buttons <= '0;
    end else begin
      o_buttons <= strobe_s;
    end
  end

  btn_debounce_pulse_chk #(.N_B(N_B)) u_chk (
    .clock     (clock),
    .reset     (reset),
    .o_buttons (o_buttons),
    .o_held    (o_held)
  );

endmodule
